// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin hold arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  // Width of a counter/index able to hold value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: scans i_start+1, i_start+2, ... and i_start last.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_start,
  input  logic             i_exclude_first,
  output logic             o_found,
  output logic [ID_W-1:0]  o_winner
);

  // w_idx[k] is the requester checked at priority position k (0 = highest).
  logic [ID_W-1:0] w_idx [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      w_idx[k] = ID_W'((int'(i_start) + k + 1) % N_REQ);
    end
  end

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  // i_exclude_first drops the pointer index itself (the current owner) from the scan.
  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[w_idx[k]] && !((k == N_REQ - 1) && i_exclude_first)) begin
        o_found  = 1'b1;
        o_winner = w_idx[k];
      end
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter: grant held while requested, revoked after MAX_HOLD cycles.
// Define ARB_SVA_EN to compile in embedded concurrent assertions.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     preempt
);

  localparam int ID_W = clog2_min1(N_REQ);
  localparam int HC_W = clog2_min1(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LIMIT = HC_W'(MAX_HOLD);
  localparam logic [ID_W-1:0] LAST_RST   = ID_W'(N_REQ - 1);

  if ((N_REQ < 2) || (N_REQ > 16)) begin : g_bad_n_req
    $error("rr_hold_arbiter: N_REQ must be in 2..16");
  end
  if (MAX_HOLD < 0) begin : g_bad_max_hold
    $error("rr_hold_arbiter: MAX_HOLD must be >= 0");
  end

  arb_state_t      r_state,   w_state_nx;
  logic [N_REQ-1:0] r_gnt,    w_gnt_nx;
  logic [ID_W-1:0] r_gnt_id,  w_gnt_id_nx;
  logic [ID_W-1:0] r_last_id, w_last_nx;
  logic [HC_W-1:0] r_hold_cnt, w_hold_nx;
  logic            r_preempt, w_preempt_nx;
  logic            r_gnt_valid;

  logic            w_owner_req;
  logic            w_hold_ok;
  logic            w_repick;
  logic            w_excl;
  logic            w_found;
  logic [ID_W-1:0] w_winner;

  // While granted, r_last_id is the current owner.
  assign w_owner_req = req[r_last_id];
  assign w_hold_ok   = (MAX_HOLD == 0) || (r_hold_cnt < HOLD_LIMIT);
  assign w_excl      = (r_state == GRANTED) && !w_owner_req;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req           (req),
    .i_start         (r_last_id),
    .i_exclude_first (w_excl),
    .o_found         (w_found),
    .o_winner        (w_winner)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_gnt_id_nx  = r_gnt_id;
    w_last_nx    = r_last_id;
    w_hold_nx    = r_hold_cnt;
    w_preempt_nx = 1'b0;
    w_repick     = 1'b0;

    case (r_state)
      IDLE: w_repick = 1'b1;
      GRANTED: begin
        if (w_owner_req && w_hold_ok) begin
          // Saturates only in the unlimited case; otherwise the limit stops it first.
          if (r_hold_cnt != '1) w_hold_nx = r_hold_cnt + 1'b1;
        end else begin
          w_preempt_nx = w_owner_req;
          w_repick     = 1'b1;
        end
      end
    endcase

    // A preempted owner remains a candidate, but in last position, so it can be re-granted.
    if (w_repick) begin
      if (w_found) begin
        w_state_nx           = GRANTED;
        w_gnt_nx             = '0;
        w_gnt_nx[w_winner]   = 1'b1;
        w_gnt_id_nx          = w_winner;
        w_last_nx            = w_winner;
        w_hold_nx            = HC_W'(1);
      end else begin
        w_state_nx  = IDLE;
        w_gnt_nx    = '0;
        w_gnt_id_nx = '0;
        w_hold_nx   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_last_id   <= LAST_RST;
      r_hold_cnt  <= '0;
      r_preempt   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_gnt       <= w_gnt_nx;
      r_gnt_valid <= |w_gnt_nx;
      r_gnt_id    <= w_gnt_id_nx;
      r_last_id   <= w_last_nx;
      r_hold_cnt  <= w_hold_nx;
      r_preempt   <= w_preempt_nx;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign preempt   = r_preempt;

`ifdef ARB_SVA_EN
  localparam int WAIT_BOUND = (N_REQ - 1) * MAX_HOLD + 1;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
  a_preempt: assert property (@(posedge clk) disable iff (!rst_n)
    preempt |-> ($past(r_hold_cnt) == HOLD_LIMIT));

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_sva
    a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
      gnt[gi] |-> $past(req[gi]));
  end

  // Bounded wait: count consecutive sampled cycles a request waits ungranted.
  if (MAX_HOLD > 0) begin : g_wait_sva
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      int r_wait;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_wait <= 0;
        else if (req[gi] && !gnt[gi]) r_wait <= r_wait + 1;
        else                         r_wait <= 0;
      end
      a_wait: assert property (@(posedge clk) disable iff (!rst_n) r_wait <= WAIT_BOUND);
    end
  end
`endif

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Randomized self-checking bench for rr_hold_arbiter against a behavioural owner/pointer model.
module tb_rr_hold_arbiter;
  localparam int N = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_a = '0;
  logic [N-1:0] req_b = '0;
  logic [N-1:0] gnt_a, gnt_b;
  logic         gv_a, gv_b;
  logic [1:0]   id_a, id_b;
  logic         pre_a, pre_b;

  int n_checks = 0;
  int n_err    = 0;

  // Model: owner (-1 = nobody), cycles held, rotating pointer, preempt pulse.
  int m_owner [2] = '{-1, -1};
  int m_hold  [2] = '{0, 0};
  int m_last  [2] = '{N - 1, N - 1};
  int m_pre   [2] = '{0, 0};

  rr_hold_arbiter #(.N_REQ(N), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a),
    .gnt_valid(gv_a), .gnt_id(id_a), .preempt(pre_a)
  );

  rr_hold_arbiter #(.N_REQ(N), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b),
    .gnt_valid(gv_b), .gnt_id(id_b), .preempt(pre_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] r, input int i);
    logic [1:0] ix;
    ix = 2'(i);
    return r[ix];
  endfunction

  function automatic int first_requester(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (bit_of(r, (last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_hold[u]  = 0;
      m_last[u]  = N - 1;
      m_pre[u]   = 0;
    end
  endtask

  task automatic model_step(input int u, input logic [N-1:0] r);
    int mh;
    int w;
    bit owner_wants;
    mh = (u == 0) ? 4 : 0;
    m_pre[u] = 0;
    owner_wants = (m_owner[u] >= 0) && bit_of(r, m_owner[u]);
    if (owner_wants && (mh == 0 || m_hold[u] < mh)) begin
      if (mh > 0) m_hold[u]++;
    end else begin
      m_pre[u] = owner_wants ? 1 : 0;
      w = first_requester(r, m_last[u]);
      if (w >= 0) begin
        m_owner[u] = w;
        m_last[u]  = w;
        m_hold[u]  = 1;
      end else begin
        m_owner[u] = -1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, req_a);
      model_step(1, req_b);
    end
  end

  task automatic check_unit(input string nm, input int u, input logic [N-1:0] g,
                            input logic gv, input logic [1:0] id, input logic pre);
    int eg;
    eg = (m_owner[u] >= 0) ? (1 << m_owner[u]) : 0;
    check({nm, ".gnt"}, int'(g), eg);
    check({nm, ".gnt_valid"}, int'(gv), (eg != 0) ? 1 : 0);
    check({nm, ".gnt_id"}, int'(id), (m_owner[u] >= 0) ? m_owner[u] : 0);
    check({nm, ".preempt"}, int'(pre), m_pre[u]);
  endtask

  always @(negedge clk) begin
    check_unit("model_a", 0, gnt_a, gv_a, id_a, pre_a);
    check_unit("model_b", 1, gnt_b, gv_b, id_b, pre_b);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with every requester active.
    req_a = 4'b1111;
    req_b = 4'b1111;
    repeat (3) begin
      cyc();
      check("rst_gnt", int'(gnt_a), 0);
      check("rst_valid", int'(gv_a), 0);
      check("rst_id", int'(id_a), 0);
      check("rst_preempt", int'(pre_a), 0);
    end
    req_a = '0;
    req_b = '0;
    rst_n = 1'b1;

    // Single requester, two cycles.
    req_a = 4'b0100;
    cyc();
    check("single_c1", int'(gnt_a), 4'b0100);
    check("single_id", int'(id_a), 2);
    cyc();
    check("single_c2", int'(gnt_a), 4'b0100);
    req_a = '0;
    cyc();
    check("single_drop", int'(gnt_a), 0);

    // All requesting: rotation with preemption every 4 cycles.
    do_reset();
    req_a = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("rot_gnt", int'(gnt_a), 1 << (((k - 1) / 4) % 4));
      check("rot_preempt", int'(pre_a), (k > 1 && ((k - 1) % 4) == 0) ? 1 : 0);
    end
    req_a = '0;
    cyc();

    // Pointer at 1, then 1 and 3 rise together: 3 wins.
    do_reset();
    req_a = 4'b0010;
    cyc();
    check("ptr_setup", int'(gnt_a), 4'b0010);
    req_a = '0;
    cyc();
    check("ptr_idle", int'(gnt_a), 0);
    req_a = 4'b1010;
    cyc();
    check("ptr_rotate", int'(gnt_a), 4'b1000);

    // Asynchronous reset mid-grant.
    do_reset();
    req_a = 4'b0010;
    cyc();
    check("async_pre", int'(gnt_a), 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", int'(gnt_a), 0);
    check("async_valid", int'(gv_a), 0);
    check("async_id", int'(id_a), 0);
    req_a = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("async_restart", int'(gnt_a), 4'b0001);
    req_a = '0;

    // Unlimited hold: owner 0 keeps the grant.
    do_reset();
    req_b = 4'b0011;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("nohold_gnt", int'(gnt_b), 4'b0001);
      check("nohold_preempt", int'(pre_b), 0);
    end
    req_b = '0;
    cyc();

    // Random traffic, checked every cycle against the model.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) req_a = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 4'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter that shares one resource among N_REQ requesters.
- Grant is registered, one-hot and held while the owner keeps requesting.
- Grant is revoked when the owner drops its request or after MAX_HOLD cycles (preemption).
- Its outputs are the signals our concurrent-assertion benches check: mutual exclusion, grant implies request, bounded wait.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 4, maximum consecutive grant cycles per owner; 0 = unlimited (no preemption).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  request vector; req[i] high = requester i wants the resource.
- gnt  output  N_REQ  one-hot-or-zero grant vector, registered.
- gnt_valid  output  1  high when any gnt bit is set (registered, equals |gnt).
- gnt_id  output  $clog2(N_REQ)  index of current owner; 0 when gnt_valid=0.
- preempt  output  1  one-cycle pulse on the cycle a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - state=IDLE, hold_cnt=0.
  - rr pointer last_id=N_REQ-1, so req[0] has top priority after reset.
- Priority order for every pick: last_id+1, last_id+2, ... wrapping modulo N_REQ, with last_id itself checked last.
- State IDLE:
  - At a posedge with req!=0: pick the winner, set gnt[w]=1, gnt_id=w, last_id=w, hold_cnt=1, go to GRANTED.
  - Latency is exactly one cycle from req sampled high to gnt high.
- State GRANTED, evaluated at each posedge with owner o:
  - Continue: req[o]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD). Keep gnt; hold_cnt++ (saturating when MAX_HOLD=0).
  - Release: req[o]=0. Re-pick from the other requesters in the same edge.
  - Preempt: req[o]=1 and hold_cnt==MAX_HOLD. Assert preempt for one cycle and re-pick in the same edge. The owner is a candidate only in last position.
  - Re-pick with a winner: gnt switches directly to the new one-hot value with no idle cycle; hold_cnt=1; last_id=winner.
  - Re-pick with no candidate: gnt=0, go to IDLE, last_id unchanged.
- After preemption, if only the owner still requests, it is re-granted immediately (gnt stays set, hold_cnt=1, preempt still pulses).
- Simultaneous rising requests resolve purely by rotating priority, never by index.
- A request dropped while not granted is simply ignored; there is no request latching.
- Fairness guarantee: a held request is granted within (N_REQ-1)*MAX_HOLD+1 cycles when MAX_HOLD>0.
- Width: hold_cnt is $clog2(MAX_HOLD+1) bits, minimum 1.
- Reset mid-grant: outputs clear immediately without a clock edge; arbitration restarts from the reset state.

Optional Feature:
- Macro: ARB_SVA_EN.
- When defined, the block compiles in embedded concurrent assertions clocked on posedge clk and disabled while !rst_n:
  - $onehot0(gnt).
  - gnt[i] implies $past(req[i]).
  - gnt_valid == |gnt.
  - preempt implies $past(hold_cnt)==MAX_HOLD.
  - Bounded wait: req[i] held high implies gnt[i] within (N_REQ-1)*MAX_HOLD+1 cycles, when MAX_HOLD>0.
- When not defined, no assertion code is present and RTL behaviour is identical.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {IDLE, GRANTED} arb_state_t.
  - Function clog2_min1 for counter and index widths.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector, start index, exclude_first flag.
  - Outputs: found, winner index.
  - Instantiated once for all IDLE and re-pick decisions.

Test Plan (N_REQ=4, MAX_HOLD=4 unless noted):
- Hold rst_n=0 with req=4'b1111 for 3 edges -> gnt=0, gnt_valid=0, gnt_id=0, preempt=0 throughout.
- req=4'b0100 for 2 cycles, then 0 -> gnt=4'b0100 on the edge after req rises, held 2 cycles, gnt=0 one edge after req falls; gnt_id=2.
- req=4'b1111 held 20 cycles -> owners 0,1,2,3,0, each exactly 4 cycles; preempt pulses at each switch; no gnt=0 gap.
- last_id=1, IDLE, then req[1] and req[3] rise together -> gnt=4'b1000 next edge.
- Assert rst_n=0 mid-cycle during gnt=4'b0010 -> gnt clears without an edge; after release with req=4'b0011, first grant is 4'b0001.
- MAX_HOLD=0, req=4'b0011 held 20 cycles starting from owner 0 -> gnt=4'b0001 for all 20 cycles, preempt never asserts.
